// File: rtl/gerenciador_consulta_caminho_if.sv
// Signal bundle between the host, the path-search core and gerenciador_consulta_caminho.
// Node width defaults to the project-wide `ADDR_WIDTH define.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

interface gerenciador_consulta_caminho_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int LEN_WIDTH  = 9
);
    logic                  host_start_in;
    logic [ADDR_WIDTH-1:0] host_fonte_in;
    logic [ADDR_WIDTH-1:0] host_destino_in;
    logic                  host_busy_out;

    logic                  top_wr_fonte_out;
    logic [ADDR_WIDTH-1:0] top_addr_fonte_out;
    logic [ADDR_WIDTH-1:0] top_addr_destino_out;

    logic                  gma_pronto_in;
    logic [ADDR_WIDTH-1:0] gma_read_data_in;

    logic                  caminho_valid_out;
    logic                  caminho_ready_in;
    logic [ADDR_WIDTH-1:0] caminho_data_out;
    logic                  caminho_last_out;
    logic [LEN_WIDTH-1:0]  caminho_len_out;

    logic                  erro_overflow_out;
    logic                  erro_timeout_out;

    modport master (
        output host_start_in, host_fonte_in, host_destino_in,
        output gma_pronto_in, gma_read_data_in,
        output caminho_ready_in,
        input  host_busy_out, top_wr_fonte_out, top_addr_fonte_out, top_addr_destino_out,
        input  caminho_valid_out, caminho_data_out, caminho_last_out, caminho_len_out,
        input  erro_overflow_out, erro_timeout_out
    );

    modport slave (
        input  host_start_in, host_fonte_in, host_destino_in,
        input  gma_pronto_in, gma_read_data_in,
        input  caminho_ready_in,
        output host_busy_out, top_wr_fonte_out, top_addr_fonte_out, top_addr_destino_out,
        output caminho_valid_out, caminho_data_out, caminho_last_out, caminho_len_out,
        output erro_overflow_out, erro_timeout_out
    );
endinterface

// File: rtl/gerenciador_consulta_caminho.sv
// Issues a path query to the core, stacks the destination-first node stream and replays it source-first.
// Optional watchdog on the capture phase is built when CAMINHO_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for host_start_in
// DISPARO | one-cycle command pulse to the core
// ESPERA  | pushing nodes from the core until the source node arrives
// SAIDA   | popping nodes to the host over valid/ready
// ERRO    | overflow or timeout; flags held until the next start
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

module gerenciador_consulta_caminho #(
    parameter int ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int MAX_CAMINHO    = 256,
    parameter int TIMEOUT_CICLOS = 65535,
    parameter int LEN_WIDTH      = $clog2(MAX_CAMINHO) + 1
) (
    input  logic clk,
    input  logic rst,
    gerenciador_consulta_caminho_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_CAMINHO);
    localparam logic [LEN_WIDTH-1:0] PILHA_CHEIA = LEN_WIDTH'(MAX_CAMINHO);
    localparam logic [LEN_WIDTH-1:0] UM_NO       = LEN_WIDTH'(1);

    if (MAX_CAMINHO < 2 || (MAX_CAMINHO & (MAX_CAMINHO - 1)) != 0) begin : g_chk_max
        $error("MAX_CAMINHO must be a power of two, at least 2");
    end
    if (TIMEOUT_CICLOS < 1) begin : g_chk_timeout
        $error("TIMEOUT_CICLOS must be at least 1");
    end
    if (LEN_WIDTH < IDX_W + 1) begin : g_chk_len
        $error("LEN_WIDTH too narrow to count MAX_CAMINHO nodes");
    end

    typedef enum logic [2:0] {
        IDLE,
        DISPARO,
        ESPERA,
        SAIDA,
        ERRO
    } estado_t;

    estado_t estado;
    estado_t proximo;

    logic [ADDR_WIDTH-1:0] fonte_q;
    logic [ADDR_WIDTH-1:0] destino_q;
    logic [ADDR_WIDTH-1:0] pilha [MAX_CAMINHO];
    logic [LEN_WIDTH-1:0]  sp;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  erro_ov_q;
    logic [IDX_W-1:0]      idx_topo;
    logic                  cheia;

    logic aceita_start;
    logic empilha;
    logic fim_captura;
    logic desempilha;
    logic set_ov;

`ifdef CAMINHO_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TO_W-1:0] TO_FIM = TO_W'(TIMEOUT_CICLOS - 1);

    logic [TO_W-1:0] to_cnt;
    logic            erro_to_q;
    logic            set_to;
`endif

    assign cheia    = (sp == PILHA_CHEIA);
    // Top of stack is sp-1; at sp == MAX_CAMINHO the low bits wrap to 0 and the subtraction lands on the last slot.
    assign idx_topo = sp[IDX_W-1:0] - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo      = estado;
        aceita_start = 1'b0;
        empilha      = 1'b0;
        fim_captura  = 1'b0;
        desempilha   = 1'b0;
        set_ov       = 1'b0;
`ifdef CAMINHO_TIMEOUT_EN
        set_to       = 1'b0;
`endif
        case (estado)
            IDLE, ERRO: begin
                if (bus.host_start_in) begin
                    aceita_start = 1'b1;
                    proximo      = DISPARO;
                end
            end
            DISPARO: begin
                proximo = ESPERA;
            end
            ESPERA: begin
                if (bus.gma_pronto_in) begin
                    if (cheia) begin
                        set_ov  = 1'b1;
                        proximo = ERRO;
                    end else begin
                        empilha = 1'b1;
                        if (bus.gma_read_data_in == fonte_q) begin
                            fim_captura = 1'b1;
                            proximo     = SAIDA;
                        end
                    end
                end
`ifdef CAMINHO_TIMEOUT_EN
                else if (to_cnt == TO_FIM) begin
                    set_to  = 1'b1;
                    proximo = ERRO;
                end
`endif
            end
            SAIDA: begin
                if (bus.caminho_ready_in) begin
                    desempilha = 1'b1;
                    if (sp == UM_NO) begin
                        proximo = IDLE;
                    end
                end
            end
            default: begin
                proximo = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fonte_q   <= '0;
            destino_q <= '0;
            sp        <= '0;
            len_q     <= '0;
            erro_ov_q <= 1'b0;
        end else begin
            if (aceita_start) begin
                fonte_q   <= bus.host_fonte_in;
                destino_q <= bus.host_destino_in;
                sp        <= '0;
                len_q     <= '0;
                erro_ov_q <= 1'b0;
            end
            if (empilha) begin
                sp <= sp + 1'b1;
            end
            if (fim_captura) begin
                len_q <= sp + 1'b1;
            end
            if (desempilha) begin
                sp <= sp - 1'b1;
            end
            if (set_ov) begin
                erro_ov_q <= 1'b1;
            end
        end
    end

    // Stack contents survive reset; sp alone defines what is live.
    always_ff @(posedge clk) begin
        if (empilha) begin
            pilha[sp[IDX_W-1:0]] <= bus.gma_read_data_in;
        end
    end

`ifdef CAMINHO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            erro_to_q <= 1'b0;
        end else begin
            if (estado != ESPERA || bus.gma_pronto_in) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (aceita_start) begin
                erro_to_q <= 1'b0;
            end
            if (set_to) begin
                erro_to_q <= 1'b1;
            end
        end
    end

    assign bus.erro_timeout_out = erro_to_q;
`else
    assign bus.erro_timeout_out = 1'b0;
`endif

    assign bus.host_busy_out        = (estado != IDLE) && (estado != ERRO);
    assign bus.top_wr_fonte_out     = (estado == DISPARO);
    assign bus.top_addr_fonte_out   = fonte_q;
    assign bus.top_addr_destino_out = destino_q;
    assign bus.caminho_valid_out    = (estado == SAIDA);
    assign bus.caminho_data_out     = (estado == SAIDA) ? pilha[idx_topo] : '0;
    assign bus.caminho_last_out     = (estado == SAIDA) && (sp == UM_NO);
    assign bus.caminho_len_out      = len_q;
    assign bus.erro_overflow_out    = erro_ov_q;

endmodule

// File: tb/tb_gerenciador_consulta_caminho.sv
// Bench for gerenciador_consulta_caminho: table vectors, directed corner sequences and random paths
// checked against a queue model (core stream reversed = host stream).
module tb_gerenciador_consulta_caminho;

    localparam int AW    = 8;
    localparam int MAXC  = 16;
    localparam int LW    = 5;
    localparam int MAXC2 = 4;
    localparam int LW2   = 3;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gerenciador_consulta_caminho_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW))  bus  ();
    gerenciador_consulta_caminho_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW2)) bus2 ();

    gerenciador_consulta_caminho #(
        .ADDR_WIDTH(AW), .MAX_CAMINHO(MAXC), .TIMEOUT_CICLOS(TO), .LEN_WIDTH(LW)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    gerenciador_consulta_caminho #(
        .ADDR_WIDTH(AW), .MAX_CAMINHO(MAXC2), .TIMEOUT_CICLOS(TO), .LEN_WIDTH(LW2)
    ) dut_pequeno (.clk(clk), .rst(rst), .bus(bus2));

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] nos_q [$];

    typedef struct {
        logic [AW-1:0]            fonte;
        logic [AW-1:0]            destino;
        int                       n;
        logic [MAXC-1:0][AW-1:0]  nos;
        logic [15:0]              rdy_pat;
        int                       exp_len;
        logic [AW-1:0]            exp_primeiro;
        logic [AW-1:0]            exp_ultimo;
    } vec_t;

    vec_t tab [4];

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nome, got, exp);
        end
    endtask

    task automatic chk_zeros(input string tag);
        chk({tag, "_busy"},  32'(bus.host_busy_out), 0);
        chk({tag, "_wr"},    32'(bus.top_wr_fonte_out), 0);
        chk({tag, "_afnt"},  32'(bus.top_addr_fonte_out), 0);
        chk({tag, "_adst"},  32'(bus.top_addr_destino_out), 0);
        chk({tag, "_valid"}, 32'(bus.caminho_valid_out), 0);
        chk({tag, "_data"},  32'(bus.caminho_data_out), 0);
        chk({tag, "_last"},  32'(bus.caminho_last_out), 0);
        chk({tag, "_len"},   32'(bus.caminho_len_out), 0);
        chk({tag, "_ovf"},   32'(bus.erro_overflow_out), 0);
        chk({tag, "_to"},    32'(bus.erro_timeout_out), 0);
    endtask

    // Runs one full query on the main DUT; nos_q holds the core stream (destination-first).
    task automatic run_path(input logic [AW-1:0] f, input logic [AW-1:0] d, input bit rnd_rdy,
                            input logic [15:0] pat, input bit ruido,
                            output logic [AW-1:0] got_pri, output logic [AW-1:0] got_ult);
        logic [AW-1:0] exp_q [$];
        int idx;
        int cyc;
        int k;
        bit r;
        exp_q.delete();
        foreach (nos_q[i]) exp_q.push_front(nos_q[i]);
        got_pri = '0;
        got_ult = '0;

        @(negedge clk);
        bus.host_start_in   = 1'b1;
        bus.host_fonte_in   = f;
        bus.host_destino_in = d;
        @(negedge clk);
        bus.host_start_in = 1'b0;
        chk("wr_pulse",     32'(bus.top_wr_fonte_out), 1);
        chk("busy_disparo", 32'(bus.host_busy_out), 1);
        chk("addr_fonte",   32'(bus.top_addr_fonte_out), 32'(f));
        chk("addr_destino", 32'(bus.top_addr_destino_out), 32'(d));
        chk("len_clear",    32'(bus.caminho_len_out), 0);
        @(negedge clk);
        chk("wr_one_cycle", 32'(bus.top_wr_fonte_out), 0);
        foreach (nos_q[i]) begin
            chk("valid_captura", 32'(bus.caminho_valid_out), 0);
            bus.gma_pronto_in    = 1'b1;
            bus.gma_read_data_in = nos_q[i];
            @(negedge clk);
        end
        bus.gma_pronto_in = 1'b0;

        idx = 0;
        cyc = 0;
        k   = 0;
        while (idx < exp_q.size() && cyc < 400) begin
            chk("valid_saida", 32'(bus.caminho_valid_out), 1);
            chk("data_saida",  32'(bus.caminho_data_out), 32'(exp_q[idx]));
            chk("last_saida",  32'(bus.caminho_last_out), 32'(idx == exp_q.size() - 1));
            chk("len_saida",   32'(bus.caminho_len_out), 32'(exp_q.size()));
            if (idx == 0) got_pri = bus.caminho_data_out;
            if (idx == exp_q.size() - 1) got_ult = bus.caminho_data_out;
            if (rnd_rdy) r = 1'($urandom_range(0, 1));
            else         r = (k < 16) ? pat[k] : 1'b1;
            k++;
            bus.caminho_ready_in = r;
            if (ruido) begin
                bus.host_start_in    = 1'($urandom_range(0, 1));
                bus.host_fonte_in    = AW'($urandom);
                bus.gma_pronto_in    = 1'($urandom_range(0, 1));
                bus.gma_read_data_in = AW'($urandom);
            end
            @(negedge clk);
            if (r) idx++;
            cyc++;
        end
        chk("saida_no_prazo", 32'(cyc < 400), 1);
        bus.caminho_ready_in = 1'b0;
        bus.host_start_in    = 1'b0;
        bus.gma_pronto_in    = 1'b0;
        chk("busy_fim",       32'(bus.host_busy_out), 0);
        chk("valid_fim",      32'(bus.caminho_valid_out), 0);
        chk("len_mantido",    32'(bus.caminho_len_out), 32'(exp_q.size()));
        chk("fonte_mantida",  32'(bus.top_addr_fonte_out), 32'(f));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [AW-1:0] f;
        logic [AW-1:0] d;
        logic [AW-1:0] v;
        logic [AW-1:0] gp;
        logic [AW-1:0] gu;

        bus.host_start_in = 0; bus.host_fonte_in = 0; bus.host_destino_in = 0;
        bus.gma_pronto_in = 0; bus.gma_read_data_in = 0; bus.caminho_ready_in = 0;
        bus2.host_start_in = 0; bus2.host_fonte_in = 0; bus2.host_destino_in = 0;
        bus2.gma_pronto_in = 0; bus2.gma_read_data_in = 0; bus2.caminho_ready_in = 0;

        tab[0] = '{fonte: 8'd5, destino: 8'd9, n: 4, nos: '0, rdy_pat: 16'hFFFF,
                   exp_len: 4, exp_primeiro: 8'd5, exp_ultimo: 8'd9};
        tab[0].nos[0] = 8'd9; tab[0].nos[1] = 8'd7; tab[0].nos[2] = 8'd6; tab[0].nos[3] = 8'd5;
        tab[1] = '{fonte: 8'd3, destino: 8'd3, n: 1, nos: '0, rdy_pat: 16'hFFFF,
                   exp_len: 1, exp_primeiro: 8'd3, exp_ultimo: 8'd3};
        tab[1].nos[0] = 8'd3;
        // ready sequence 1,0,0,1,0,1,1 then held high
        tab[2] = tab[0];
        tab[2].rdy_pat = 16'hFFE9;
        tab[3] = '{fonte: 8'hAA, destino: 8'h01, n: MAXC, nos: '0, rdy_pat: 16'h5555,
                   exp_len: MAXC, exp_primeiro: 8'hAA, exp_ultimo: 8'h01};
        for (int j = 0; j < MAXC; j++) tab[3].nos[j] = (j == MAXC - 1) ? 8'hAA : AW'(j + 1);

        repeat (3) @(negedge clk);
        chk_zeros("reset");
        chk("reset_ovf2",   32'(bus2.erro_overflow_out), 0);
        chk("reset_valid2", 32'(bus2.caminho_valid_out), 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            nos_q.delete();
            for (int j = 0; j < tab[i].n; j++) nos_q.push_back(tab[i].nos[j]);
            run_path(tab[i].fonte, tab[i].destino, 1'b0, tab[i].rdy_pat, 1'b0, gp, gu);
            chk("tab_len",      32'(bus.caminho_len_out), 32'(tab[i].exp_len));
            chk("tab_primeiro", 32'(gp), 32'(tab[i].exp_primeiro));
            chk("tab_ultimo",   32'(gu), 32'(tab[i].exp_ultimo));
        end

        // Overflow on the 4-deep instance: 10..14 never reach fonte 20.
        @(negedge clk);
        bus2.host_start_in = 1; bus2.host_fonte_in = 8'd20; bus2.host_destino_in = 8'd10;
        @(negedge clk);
        bus2.host_start_in = 0;
        @(negedge clk);
        for (int j = 10; j <= 14; j++) begin
            chk("ovf_valid_cap", 32'(bus2.caminho_valid_out), 0);
            chk("ovf_flag_cedo", 32'(bus2.erro_overflow_out), 0);
            bus2.gma_pronto_in = 1; bus2.gma_read_data_in = AW'(j);
            @(negedge clk);
        end
        bus2.gma_pronto_in = 0;
        chk("ovf_flag",  32'(bus2.erro_overflow_out), 1);
        chk("ovf_busy",  32'(bus2.host_busy_out), 0);
        chk("ovf_valid", 32'(bus2.caminho_valid_out), 0);
        @(negedge clk);
        chk("ovf_sticky",       32'(bus2.erro_overflow_out), 1);
        chk("ovf_valid_depois", 32'(bus2.caminho_valid_out), 0);
        bus2.host_start_in = 1; bus2.host_fonte_in = 8'd7; bus2.host_destino_in = 8'd7;
        @(negedge clk);
        bus2.host_start_in = 0;
        chk("ovf_limpo", 32'(bus2.erro_overflow_out), 0);
        chk("ovf_wr",    32'(bus2.top_wr_fonte_out), 1);
        @(negedge clk);
        bus2.gma_pronto_in = 1; bus2.gma_read_data_in = 8'd7;
        @(negedge clk);
        bus2.gma_pronto_in = 0;
        chk("ovf_rec_valid", 32'(bus2.caminho_valid_out), 1);
        chk("ovf_rec_data",  32'(bus2.caminho_data_out), 7);
        chk("ovf_rec_last",  32'(bus2.caminho_last_out), 1);
        chk("ovf_rec_len",   32'(bus2.caminho_len_out), 1);
        bus2.caminho_ready_in = 1;
        @(negedge clk);
        bus2.caminho_ready_in = 0;
        chk("ovf_rec_busy", 32'(bus2.host_busy_out), 0);

        // Watchdog: start with no core response.
        @(negedge clk);
        bus.host_start_in = 1; bus.host_fonte_in = 8'h42; bus.host_destino_in = 8'h43;
        @(negedge clk);
        bus.host_start_in = 0;
`ifdef CAMINHO_TIMEOUT_EN
        repeat (TO) @(negedge clk);
        chk("to_ainda_nao", 32'(bus.erro_timeout_out), 0);
        chk("to_busy_espera", 32'(bus.host_busy_out), 1);
        @(negedge clk);
        chk("to_flag", 32'(bus.erro_timeout_out), 1);
        chk("to_busy", 32'(bus.host_busy_out), 0);
        chk("to_valid", 32'(bus.caminho_valid_out), 0);
        bus.host_start_in = 1;
        @(negedge clk);
        bus.host_start_in = 0;
        chk("to_limpo", 32'(bus.erro_timeout_out), 0);
`else
        repeat (100) @(negedge clk);
        chk("espera_busy", 32'(bus.host_busy_out), 1);
        chk("espera_to",   32'(bus.erro_timeout_out), 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        chk_zeros("rst_espera");
        rst = 1'b0;

        // Reset after two pops in SAIDA.
        nos_q = '{8'd9, 8'd7, 8'd6, 8'd5};
        @(negedge clk);
        bus.host_start_in = 1; bus.host_fonte_in = 8'd5; bus.host_destino_in = 8'd9;
        @(negedge clk);
        bus.host_start_in = 0;
        @(negedge clk);
        foreach (nos_q[i]) begin
            bus.gma_pronto_in = 1; bus.gma_read_data_in = nos_q[i];
            @(negedge clk);
        end
        bus.gma_pronto_in = 0;
        bus.caminho_ready_in = 1;
        repeat (2) @(negedge clk);
        chk("meio_saida_data", 32'(bus.caminho_data_out), 7);
        rst = 1'b1;
        @(negedge clk);
        chk_zeros("rst_saida");
        rst = 1'b0;
        bus.caminho_ready_in = 0;
        run_path(8'd5, 8'd9, 1'b0, 16'hFFFF, 1'b1, gp, gu);
        chk("pos_rst_pri", 32'(gp), 5);
        chk("pos_rst_ult", 32'(gu), 9);

        // Random paths: only the final node equals fonte.
        for (int t = 0; t < 40; t++) begin
            n = (t % 8 == 0) ? MAXC : int'($urandom_range(1, MAXC));
            f = AW'($urandom);
            if (n == 1) d = f;
            else begin
                d = AW'($urandom);
                while (d == f) d = AW'($urandom);
            end
            nos_q.delete();
            for (int j = 0; j < n; j++) begin
                if (j == n - 1) v = f;
                else if (j == 0) v = d;
                else begin
                    v = AW'($urandom);
                    while (v == f) v = AW'($urandom);
                end
                nos_q.push_back(v);
            end
            run_path(f, d, 1'b1, 16'hFFFF, t[0], gp, gu);
            chk("rnd_pri", 32'(gp), 32'(f));
            chk("rnd_ult", 32'(gu), 32'(d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
